// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared function-code fields, unit encodings and FSM states
package alu_pkg;

  localparam int FUN_W        = 4;
  localparam int FUN_UNIT_LSB = 2;
  localparam int FUN_SUB_LSB  = 0;

  typedef enum logic [1:0] {
    UNIT_ARITH = 2'b00,
    UNIT_LOGIC = 2'b01,
    UNIT_CMP   = 2'b10,
    UNIT_SHIFT = 2'b11
  } unit_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  typedef struct packed {
    unit_sel_e  unit;
    logic [1:0] sub;
  } fun_dec_t;

  // Split a 4-bit function code into unit select and sub-function.
  function automatic fun_dec_t decode_fun(input logic [FUN_W-1:0] fun);
    fun_dec_t d;
    d.unit = unit_sel_e'(fun[FUN_UNIT_LSB +: 2]);
    d.sub  = fun[FUN_SUB_LSB +: 2];
    return d;
  endfunction

  // One-hot enable vector, bit index equals the unit encoding.
  function automatic logic [3:0] unit_onehot(input unit_sel_e u);
    logic [3:0] oh;
    oh    = 4'b0000;
    oh[u] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/alu_req_scheduler_if.sv
// rtl/alu_req_scheduler_if.sv - requester, response and ALU-side signal bundle
interface alu_req_scheduler_if #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 16
);

  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [2*IN_WIDTH-1:0] req_a;
  logic [2*IN_WIDTH-1:0] req_b;
  logic [7:0]            req_fun;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic [OUT_WIDTH-1:0]  rsp_data;
  logic                  rsp_flag;

  logic [IN_WIDTH-1:0]   alu_a;
  logic [IN_WIDTH-1:0]   alu_b;
  logic [1:0]            alu_fun;
  logic                  arith_en;
  logic                  logic_en;
  logic                  cmp_en;
  logic                  shift_en;
  logic [OUT_WIDTH-1:0]  alu_out;
  logic                  alu_flag;

  // Scheduler side.
  modport slave (
    input  req_valid, req_a, req_b, req_fun, rsp_ready, alu_out, alu_flag,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_flag,
    output alu_a, alu_b, alu_fun, arith_en, logic_en, cmp_en, shift_en
  );

  // Clients plus ALU side.
  modport master (
    output req_valid, req_a, req_b, req_fun, rsp_ready, alu_out, alu_flag,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_flag,
    input  alu_a, alu_b, alu_fun, arith_en, logic_en, cmp_en, shift_en
  );

endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-input round-robin grant, purely combinational
module rr_arbiter2 (
  input  logic [1:0] i_req_valid,
  input  logic       i_rr_ptr,
  output logic       o_gnt_idx,
  output logic       o_gnt_valid
);

  // A lone requester wins outright; on contention the pointer decides.
  always_comb begin
    o_gnt_valid = |i_req_valid;
    o_gnt_idx   = 1'b0;
    case (i_req_valid)
      2'b01:   o_gnt_idx = 1'b0;
      2'b10:   o_gnt_idx = 1'b1;
      2'b11:   o_gnt_idx = i_rr_ptr;
      default: o_gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// rtl/alu_req_scheduler.sv - shares one multi-unit ALU between two requesters
module alu_req_scheduler
  import alu_pkg::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 16,
  parameter int UNIT_LAT  = 1
) (
  input  logic               clk,
  input  logic               RST,
  alu_req_scheduler_if.slave bus
);

  // Counter reload; UNIT_LAT is expected in 1..7 so it fits three bits.
  localparam logic [2:0] LAT_LOAD = 3'(UNIT_LAT - 1);

  state_e                r_state;
  logic                  r_rr_ptr;
  logic [2:0]            r_lat_cnt;
  logic [3:0]            r_en;
  logic [IN_WIDTH-1:0]   r_alu_a;
  logic [IN_WIDTH-1:0]   r_alu_b;
  logic [1:0]            r_alu_fun;
  logic                  r_id;
  logic                  r_rsp_valid;
  logic [OUT_WIDTH-1:0]  r_rsp_data;
  logic                  r_rsp_flag;

  logic                  w_gnt_idx;
  logic                  w_gnt_valid;
  logic                  w_accept;
  logic [IN_WIDTH-1:0]   w_sel_a;
  logic [IN_WIDTH-1:0]   w_sel_b;
  logic [FUN_W-1:0]      w_sel_fun;
  fun_dec_t              w_dec;

  rr_arbiter2 u_arb (
    .i_req_valid (bus.req_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_gnt_idx   (w_gnt_idx),
    .o_gnt_valid (w_gnt_valid)
  );

  assign w_sel_a   = w_gnt_idx ? bus.req_a[2*IN_WIDTH-1:IN_WIDTH] : bus.req_a[IN_WIDTH-1:0];
  assign w_sel_b   = w_gnt_idx ? bus.req_b[2*IN_WIDTH-1:IN_WIDTH] : bus.req_b[IN_WIDTH-1:0];
  assign w_sel_fun = w_gnt_idx ? bus.req_fun[7:4] : bus.req_fun[3:0];
  assign w_dec     = decode_fun(w_sel_fun);

  // Accept only from IDLE and never on a reset cycle, so a requester is
  // never told it was taken when the edge is about to discard the grant.
  assign w_accept      = (r_state == ST_IDLE) && w_gnt_valid && !RST;
  assign bus.req_ready = w_accept ? (w_gnt_idx ? 2'b10 : 2'b01) : 2'b00;

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_id;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_flag  = r_rsp_flag;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_fun   = r_alu_fun;
  assign bus.arith_en  = r_en[0];
  assign bus.logic_en  = r_en[1];
  assign bus.cmp_en    = r_en[2];
  assign bus.shift_en  = r_en[3];

  // Scheduler FSM: grant, issue a one-cycle enable, wait the unit latency,
  // capture and hold the result until the consumer takes it.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= 1'b0;
      r_lat_cnt   <= 3'd0;
      r_en        <= 4'b0000;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_fun   <= 2'b00;
      r_id        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_flag  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_valid) begin
            r_alu_a   <= w_sel_a;
            r_alu_b   <= w_sel_b;
            r_alu_fun <= w_dec.sub;
            r_id      <= w_gnt_idx;
            r_en      <= unit_onehot(w_dec.unit);
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_en      <= 4'b0000;
          r_lat_cnt <= LAT_LOAD;
          r_state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_lat_cnt == 3'd0) begin
            r_rsp_data  <= bus.alu_out;
            r_rsp_flag  <= bus.alu_flag;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_lat_cnt <= r_lat_cnt - 3'd1;
          end
        end
        ST_DONE: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rr_ptr    <= ~r_id;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_en    <= 4'b0000;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_req_scheduler.md
Name: alu_req_scheduler

Overview:
- Shares one hierarchical ALU (arithmetic, logic, compare and shift units) between two requesters.
- Round-robin arbitration, one operation in flight at a time.
- Decodes the 4-bit function code into one unit enable plus a 2-bit sub-function, waits the unit's registered latency, then captures the result and flag.
- Returns them to the granted requester with a valid/ready handshake. Sits between the ALU top level and its clients.

Parameters:
- IN_WIDTH, 8, operand width.
- OUT_WIDTH, 16, result width.
- UNIT_LAT, 1, clock edges from enable-high to valid unit output (1..7).

Ports:
- clk  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous active-high reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester accept strobe
- req_a  in  2*IN_WIDTH  operand A, requester i at [i*IN_WIDTH +: IN_WIDTH]
- req_b  in  2*IN_WIDTH  operand B, same packing
- req_fun  in  8  function code, requester i at [i*4 +: 4]
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester that owns the result
- rsp_data  out  OUT_WIDTH  captured unit result
- rsp_flag  out  1  captured unit flag
- alu_a / alu_b  out  IN_WIDTH  operands to units
- alu_fun  out  2  sub-function to units (fun[1:0])
- arith_en, logic_en, cmp_en, shift_en  out  1 each  unit enables, one-hot or all zero
- alu_out  in  OUT_WIDTH  result from the selected unit
- alu_flag  in  1  flag from the selected unit

Behaviour:
- Reset: the following take effect on the clock edge with RST=1, and RST overrides everything, including a transaction mid-operation:
  - state = IDLE, rr_ptr = 0 (requester 0 has priority first)
  - all enables 0, req_ready = 0, rsp_valid = 0
  - rsp_id, rsp_data, rsp_flag, alu_a, alu_b, alu_fun = 0
  - the in-flight result is discarded.
- Unit decode, fun[3:2]: 00 arith, 01 logic, 10 cmp, 11 shift. alu_fun = fun[1:0].
- FSM state IDLE:
  - Nothing pending: stay in IDLE.
  - Exactly one req_valid: grant that requester.
  - Both valid: grant the requester rr_ptr points to.
  - On a grant:
    - pulse req_ready[g] for that single cycle (the accept cycle);
    - register operands and fun into alu_a/alu_b/alu_fun/id;
    - go to ISSUE.
  - req_ready is only ever high in IDLE with a grant, so at most one bit is high.
- FSM state ISSUE:
  - Exactly one enable is high, for exactly one cycle.
  - Load lat_cnt = UNIT_LAT-1, then go to WAIT.
  - The enable drops in every state other than ISSUE.
- FSM state WAIT:
  - lat_cnt = 0: capture alu_out -> rsp_data and alu_flag -> rsp_flag, set rsp_valid, go to DONE.
  - Otherwise decrement lat_cnt.
- FSM state DONE:
  - rsp_valid is held; rsp_data, rsp_flag and rsp_id stay stable.
  - On rsp_valid && rsp_ready: clear rsp_valid, set rr_ptr = ~rsp_id, go to IDLE.
- Latency:
  - Request accept to rsp_valid = UNIT_LAT+2 cycles.
  - Back-to-back throughput: one operation per UNIT_LAT+3 cycles, including the IDLE accept cycle.
- Operand stability: alu_a, alu_b and alu_fun stay constant from ISSUE through DONE. Requester inputs may change after their req_ready pulse.
- A requester that drops req_valid before it is granted loses nothing; the request is simply not taken.
- The grant is made only in IDLE, so a request arriving during WAIT/DONE is stalled until the next IDLE cycle.
- rsp_ready held high continuously: DONE lasts exactly one cycle.
- rsp_ready asserted while rsp_valid=0 is ignored.
- Width rule: rsp_data carries the full OUT_WIDTH unit result unmodified; no sign extension or truncation.

Decomposition:
- Shared package/header `alu_pkg`:
  - function-code field positions;
  - unit-select encodings (ARITH=2'b00, LOGIC=2'b01, CMP=2'b10, SHIFT=2'b11);
  - FSM state encodings (IDLE, ISSUE, WAIT, DONE).
- One sub-module `rr_arbiter2`: 2-input round-robin grant, combinational from req_valid and rr_ptr, producing a grant index and a grant-valid.
- FSM, latency counter and capture registers stay in the top module.

Test Plan:
1. Reset mid-operation: req0 logic AND A=15 B=30, assert RST during WAIT -> next cycle all outputs 0, state IDLE, no rsp_valid ever for that request.
2. Single logic op, unit model with UNIT_LAT=1: req0 fun=4'b0100, A=15 B=30 -> logic_en high exactly one cycle, rsp_valid 3 cycles after accept, rsp_data=14, rsp_id=0.
3. Contention: both valid at once; req0 fun=4'b0101 A=50 B=15, req1 fun=4'b0110 A=50 B=15 -> req0 served first (rsp_data=63). After the handshake, req1 is served (rsp_data=16'hFFFD). Then, with both still valid, req0 wins again, showing strict alternation.
4. Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid, rsp_data and rsp_id stable; no new req_ready; the unit enable stays 0.
5. Decode: issue fun 4'b0011, 4'b1001, 4'b1110 -> arith_en, cmp_en and shift_en asserted respectively, with alu_fun = 11, 01, 10; the enables are never multi-hot.
6. UNIT_LAT=3 build: accept-to-rsp_valid = 5 cycles; rsp_data is sampled from alu_out at the final WAIT cycle, not earlier (the model changes alu_out each cycle).
